// File: rtl/enemy_fleet_ctrl.sv
// enemy_fleet_ctrl
//   March controller for the enemy fleet. It paces the fleet from frame_i and
//   chooses between a sideways step, a drop with direction reversal, or
//   landing, using the aggregate fleet extents. It also tracks wipe-out and
//   the respawn delay. The step/drop/dir/pixel_avail bus is shared by every ship.
//
//   state   | meaning
//   IDLE    | waiting for the first frame with a live fleet
//   MARCH_R | fleet marching toward the right wall
//   MARCH_L | fleet marching toward the left wall
//   LANDED  | fleet reached the landing line; game over until reset
//   CLEARED | fleet wiped out; counting frames until respawn
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   frame_i                 one-cycle pulse per rendered frame
//   alive_i                 per-ship alive mask
//   fleet_left/right/bot_i  extents of the live ships
//   step_o, drop_o          one-cycle move pulses (never both high)
//   dir_right_o             1 = marching right
//   pixel_avail_o           registered headroom toward the current wall
//   landed_o, cleared_o     state flags
//   respawn_o               one-cycle pulse; ships return to start positions
module enemy_fleet_ctrl #(
    parameter int num_ships_p      = 10,
    parameter int step_px_p        = 10,
    parameter int drop_px_p        = 10,
    parameter int screen_left_p    = 0,
    parameter int screen_right_p   = 639,
    parameter int land_line_p      = 440,
    parameter int base_period_p    = 60,
    parameter int min_period_p     = 4,
    parameter int respawn_frames_p = 300
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   frame_i,
    input  logic [num_ships_p-1:0] alive_i,
    input  logic [9:0]             fleet_left_i,
    input  logic [9:0]             fleet_right_i,
    input  logic [9:0]             fleet_bot_i,
    output logic                   step_o,
    output logic                   dir_right_o,
    output logic                   drop_o,
    output logic [9:0]             pixel_avail_o,
    output logic                   landed_o,
    output logic                   cleared_o,
    output logic                   respawn_o
);
    localparam int cnt_w = $clog2(base_period_p + 1);
    localparam int rsp_w = $clog2(respawn_frames_p + 1);

    localparam logic [9:0]       LEFT_PX   = 10'(screen_left_p);
    localparam logic [9:0]       RIGHT_PX  = 10'(screen_right_p);
    localparam logic [9:0]       STEP_PX   = 10'(step_px_p);
    localparam logic [9:0]       LAND_PX   = 10'(land_line_p);
    localparam logic [10:0]      DROP_PX11 = 11'(drop_px_p);
    localparam logic [10:0]      LAND_PX11 = 11'(land_line_p);
    localparam logic [rsp_w-1:0] RSP_LAST  = rsp_w'(respawn_frames_p - 1);

    typedef enum logic [2:0] {IDLE, MARCH_R, MARCH_L, LANDED, CLEARED} state_t;

    state_t           state_q, state_d;
    logic [cnt_w-1:0] frame_cnt_q, frame_cnt_d;
    logic [cnt_w-1:0] period_q, period_d;
    logic [rsp_w-1:0] rsp_cnt_q, rsp_cnt_d;
    logic             step_q, step_d;
    logic             drop_q, drop_d;
    logic             dir_q, dir_d;
    logic             respawn_q, respawn_d;
    logic [9:0]       pixel_avail_q, pixel_avail_d;
    logic [cnt_w-1:0] period_now;
    logic [10:0]      bot_after_drop;
    int               alive_cnt;
    int               dead_cnt;

    // March period shrinks by one frame per dead ship, floored.
    always_comb begin
        alive_cnt = 0;
        for (int i = 0; i < num_ships_p; i++) begin
            alive_cnt = alive_cnt + int'(alive_i[i]);
        end
        dead_cnt = num_ships_p - alive_cnt;
        if (base_period_p - dead_cnt > min_period_p) begin
            period_now = cnt_w'(base_period_p - dead_cnt);
        end else begin
            period_now = cnt_w'(min_period_p);
        end
    end

    // Headroom toward the wall being approached, saturating at zero.
    always_comb begin
        pixel_avail_d = '0;
        case (state_q)
            MARCH_R: if (fleet_right_i < RIGHT_PX) pixel_avail_d = RIGHT_PX - fleet_right_i;
            MARCH_L: if (fleet_left_i > LEFT_PX) pixel_avail_d = fleet_left_i - LEFT_PX;
            default: pixel_avail_d = '0;
        endcase
    end

    assign bot_after_drop = {1'b0, fleet_bot_i} + DROP_PX11;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        period_d    = period_q;
        rsp_cnt_d   = rsp_cnt_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        drop_d      = 1'b0;
        respawn_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_i && (alive_i != '0)) begin
                    state_d     = MARCH_R;
                    frame_cnt_d = '0;
                    period_d    = period_now;
                    dir_d       = 1'b1;
                end
            end
            MARCH_R, MARCH_L: begin
                // Wipe-out outranks landing seen in the same cycle.
                if (alive_i == '0) begin
                    state_d     = CLEARED;
                    rsp_cnt_d   = '0;
                    frame_cnt_d = '0;
                end else if (fleet_bot_i >= LAND_PX) begin
                    state_d = LANDED;
                end else if (frame_i) begin
                    if (frame_cnt_q == period_q - 1'b1) begin
                        frame_cnt_d = '0;
                        period_d    = period_now;
                        if (pixel_avail_d >= STEP_PX) begin
                            step_d = 1'b1;
                        end else if (bot_after_drop >= LAND_PX11) begin
                            state_d = LANDED;
                        end else begin
                            drop_d  = 1'b1;
                            dir_d   = ~dir_q;
                            state_d = (state_q == MARCH_R) ? MARCH_L : MARCH_R;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            CLEARED: begin
                if (frame_i) begin
                    if (rsp_cnt_q == RSP_LAST) begin
                        respawn_d   = 1'b1;
                        dir_d       = 1'b1;
                        rsp_cnt_d   = '0;
                        frame_cnt_d = '0;
                        // Ships come back as a full fleet.
                        period_d    = cnt_w'(base_period_p);
                        state_d     = MARCH_R;
                    end else begin
                        rsp_cnt_d = rsp_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            period_q      <= '0;
            rsp_cnt_q     <= '0;
            step_q        <= 1'b0;
            drop_q        <= 1'b0;
            dir_q         <= 1'b1;
            respawn_q     <= 1'b0;
            pixel_avail_q <= '0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            period_q      <= period_d;
            rsp_cnt_q     <= rsp_cnt_d;
            step_q        <= step_d;
            drop_q        <= drop_d;
            dir_q         <= dir_d;
            respawn_q     <= respawn_d;
            pixel_avail_q <= pixel_avail_d;
        end
    end

    assign step_o        = step_q;
    assign drop_o        = drop_q;
    assign dir_right_o   = dir_q;
    assign respawn_o     = respawn_q;
    assign pixel_avail_o = pixel_avail_q;
    assign landed_o      = (state_q == LANDED);
    assign cleared_o     = (state_q == CLEARED);
endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb_enemy_fleet_ctrl
//   Directed bench for enemy_fleet_ctrl: march pacing, period scaling with
//   dead ships, wall drop, landing, wipe-out/respawn and asynchronous reset.
module tb_enemy_fleet_ctrl;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       frame_i;
    logic [9:0] alive_i;
    logic [9:0] fleet_left_i;
    logic [9:0] fleet_right_i;
    logic [9:0] fleet_bot_i;
    logic       step_o;
    logic       dir_right_o;
    logic       drop_o;
    logic [9:0] pixel_avail_o;
    logic       landed_o;
    logic       cleared_o;
    logic       respawn_o;

    int n_cmp = 0;
    int n_err = 0;
    int step_cnt = 0;
    int drop_cnt = 0;
    int rsp_cnt = 0;
    int overlap_cnt = 0;
    int stray_cnt = 0;
    int s0;

    always #5 clk_i = ~clk_i;

    enemy_fleet_ctrl dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .frame_i       (frame_i),
        .alive_i       (alive_i),
        .fleet_left_i  (fleet_left_i),
        .fleet_right_i (fleet_right_i),
        .fleet_bot_i   (fleet_bot_i),
        .step_o        (step_o),
        .dir_right_o   (dir_right_o),
        .drop_o        (drop_o),
        .pixel_avail_o (pixel_avail_o),
        .landed_o      (landed_o),
        .cleared_o     (cleared_o),
        .respawn_o     (respawn_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Each frame is a one-cycle pulse; any step/drop/respawn it triggers is
    // visible at the following negedge and must be gone one cycle later.
    task automatic send_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (step_o || drop_o || respawn_o) stray_cnt++;
            frame_i = 1'b1;
            @(negedge clk_i);
            frame_i = 1'b0;
            if (step_o) step_cnt++;
            if (drop_o) drop_cnt++;
            if (respawn_o) rsp_cnt++;
            if (step_o && drop_o) overlap_cnt++;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        frame_i = 1'b0;
        idle_cycles(2);
        reset_i = 1'b0;
        idle_cycles(1);
    endtask

    initial begin
        reset_i       = 1'b1;
        frame_i       = 1'b0;
        alive_i       = '1;
        fleet_left_i  = 10'd50;
        fleet_right_i = 10'd300;
        fleet_bot_i   = 10'd100;
        #12;
        chk("rst_step",    int'(step_o), 0);
        chk("rst_drop",    int'(drop_o), 0);
        chk("rst_dir",     int'(dir_right_o), 1);
        chk("rst_pix",     int'(pixel_avail_o), 0);
        chk("rst_landed",  int'(landed_o), 0);
        chk("rst_cleared", int'(cleared_o), 0);
        chk("rst_respawn", int'(respawn_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Full fleet: start frame, then a step on the 60th frame.
        send_frames(1);
        send_frames(59);
        chk("p60_early", step_cnt, 0);
        chk("pix_right", int'(pixel_avail_o), 339);
        send_frames(1);
        chk("p60_step", step_cnt, 1);
        chk("p60_dir", int'(dir_right_o), 1);

        // Four dead: current period still 60, next sampled as 56.
        alive_i = 10'b00_0011_1111;
        send_frames(60);
        chk("p60_second", step_cnt, 2);
        send_frames(55);
        chk("p56_early", step_cnt, 2);
        send_frames(1);
        chk("p56_step", step_cnt, 3);

        // Nine dead: period 51 after the next tick.
        alive_i = 10'b00_0000_0001;
        send_frames(56);
        chk("p56_again", step_cnt, 4);
        send_frames(50);
        chk("p51_early", step_cnt, 4);
        send_frames(1);
        chk("p51_step", step_cnt, 5);

        // Right wall: headroom 4 < step, so drop and reverse.
        alive_i       = '1;
        fleet_right_i = 10'd635;
        idle_cycles(2);
        chk("pix_wall", int'(pixel_avail_o), 4);
        send_frames(51);
        chk("wall_drop", drop_cnt, 1);
        chk("wall_nostep", step_cnt, 5);
        chk("wall_dir", int'(dir_right_o), 0);
        idle_cycles(2);
        chk("pix_left", int'(pixel_avail_o), 50);

        // Headroom exactly equal to step still steps.
        fleet_left_i = 10'd10;
        send_frames(60);
        chk("edge_step", step_cnt, 6);
        chk("edge_nodrop", drop_cnt, 1);
        chk("edge_dir", int'(dir_right_o), 0);

        // Drop would reach the landing line: land instead of dropping.
        fleet_left_i = 10'd5;
        fleet_bot_i  = 10'd432;
        send_frames(59);
        chk("land_early", int'(landed_o), 0);
        send_frames(1);
        chk("land_flag", int'(landed_o), 1);
        chk("land_nodrop", drop_cnt, 1);
        chk("land_nostep", step_cnt, 6);
        send_frames(130);
        chk("land_sticky", int'(landed_o), 1);
        chk("land_quiet", step_cnt + drop_cnt, 7);

        // Wipe-out wins over a same-cycle landing, then respawn after 300 frames.
        do_reset();
        chk("rst2_landed", int'(landed_o), 0);
        alive_i       = '1;
        fleet_left_i  = 10'd50;
        fleet_right_i = 10'd300;
        fleet_bot_i   = 10'd100;
        send_frames(11);
        alive_i     = '0;
        fleet_bot_i = 10'd450;
        idle_cycles(2);
        chk("clr_flag", int'(cleared_o), 1);
        chk("clr_not_landed", int'(landed_o), 0);
        chk("clr_pix", int'(pixel_avail_o), 0);
        alive_i     = '1;
        fleet_bot_i = 10'd100;
        send_frames(299);
        chk("rsp_early", rsp_cnt, 0);
        chk("rsp_wait_flag", int'(cleared_o), 1);
        send_frames(1);
        chk("rsp_pulse", rsp_cnt, 1);
        chk("rsp_cleared", int'(cleared_o), 0);
        chk("rsp_dir", int'(dir_right_o), 1);
        s0 = step_cnt;
        send_frames(59);
        chk("rsp_p60_early", step_cnt, s0);
        send_frames(1);
        chk("rsp_p60_step", step_cnt, s0 + 1);

        // Bottom exactly on the landing line lands without waiting for a tick.
        fleet_bot_i = 10'd440;
        idle_cycles(2);
        chk("land_line", int'(landed_o), 1);

        // Reset asserted between clock edges while cleared.
        do_reset();
        alive_i     = '1;
        fleet_bot_i = 10'd100;
        send_frames(1);
        alive_i = '0;
        idle_cycles(2);
        chk("clr2_flag", int'(cleared_o), 1);
        @(posedge clk_i);
        #3;
        reset_i = 1'b1;
        #1;
        chk("arst_cleared", int'(cleared_o), 0);
        chk("arst_dir", int'(dir_right_o), 1);
        chk("arst_pix", int'(pixel_avail_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // IDLE ignores frames while nothing is alive.
        s0 = step_cnt;
        send_frames(80);
        chk("idle_nostep", step_cnt, s0);
        chk("idle_not_cleared", int'(cleared_o), 0);

        chk("no_overlap", overlap_cnt, 0);
        chk("pulse_width", stray_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
